// File: rtl/store_queue_pkg.sv
// Shared sizing, pointer type and drain-FSM encoding for the store queue.
package store_queue_pkg;
    localparam int SQ_NUM   = 8;
    localparam int SQ_SEL   = 3;
    localparam int ADDR_LEN = 32;
    localparam int DATA_LEN = 32;
    localparam int ROB_SEL  = 6;

    // Queue pointer with an extra wrap bit above the slot index.
    typedef logic [SQ_SEL:0] sq_ptr_t;

    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

    function automatic logic [SQ_SEL-1:0] slot_of(input sq_ptr_t p);
        return p[SQ_SEL-1:0];
    endfunction
endpackage

// File: rtl/store_queue_fwd_search.sv
// Youngest-older store search for load forwarding: walks from head up to the load's
// tail snapshot; the youngest valid older store must have its address known.
module sq_fwd_search
    import store_queue_pkg::*;
(
    input  logic                ld_valid,
    input  logic [ADDR_LEN-1:0] ld_addr,
    input  sq_ptr_t             ld_sq_tail,
    input  sq_ptr_t             head,
    input  logic [SQ_NUM-1:0]   valid,
    input  logic [SQ_NUM-1:0]   ready,
    input  logic [ADDR_LEN-1:0] addr [SQ_NUM],
    input  logic [DATA_LEN-1:0] data [SQ_NUM],
    output logic                hit,
    output logic [DATA_LEN-1:0] hit_data
);
    sq_ptr_t             dist_s;
    logic [SQ_SEL-1:0]   slot_s;
    logic                youngest_ready_s;
    logic                match_s;
    logic [DATA_LEN-1:0] match_data_s;

    // Ascending scan so later (younger) entries override older ones.
    always_comb begin
        dist_s           = ld_sq_tail - head;
        slot_s           = '0;
        youngest_ready_s = 1'b0;
        match_s          = 1'b0;
        match_data_s     = '0;
        for (int k = 0; k < SQ_NUM; k++) begin
            slot_s = slot_of(head + sq_ptr_t'(k));
            if ((sq_ptr_t'(k) < dist_s) && valid[slot_s]) begin
                youngest_ready_s = ready[slot_s];
                if (ready[slot_s] && (addr[slot_s] == ld_addr)) begin
                    match_s      = 1'b1;
                    match_data_s = data[slot_s];
                end else begin
                    match_s      = match_s;
                end
            end else begin
                youngest_ready_s = youngest_ready_s;
            end
        end
        hit      = ld_valid && youngest_ready_s && match_s;
        hit_data = hit ? match_data_s : '0;
    end
endmodule

// File: rtl/store_queue.sv
// In-order store buffer: dual dispatch, AGU capture, ROB commit, one-at-a-time drain
// to the D-cache and store-to-load forwarding.
module store_queue
    import store_queue_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                dispatch_sq_valid_1,
    input  logic                dispatch_sq_valid_2,
    input  logic [ROB_SEL-1:0]  rob_idx_1,
    input  logic [ROB_SEL-1:0]  rob_idx_2,
    output logic [SQ_SEL-1:0]   sq_idx_1,
    output logic [SQ_SEL-1:0]   sq_idx_2,
    input  logic                exec_valid,
    input  logic [SQ_SEL-1:0]   exec_sq_idx,
    input  logic [ADDR_LEN-1:0] exec_addr,
    input  logic [DATA_LEN-1:0] exec_data,
    input  logic [1:0]          commit_cnt,
    input  logic                flush,
    input  logic                ld_valid,
    input  logic [ADDR_LEN-1:0] ld_addr,
    input  logic [SQ_SEL:0]     ld_sq_tail,
    output logic                fwd_hit,
    output logic [DATA_LEN-1:0] fwd_data,
    output logic                mem_req_valid,
    output logic [ADDR_LEN-1:0] mem_req_addr,
    output logic [DATA_LEN-1:0] mem_req_data,
    input  logic                mem_req_ready,
    output logic                sq_full,
    output logic                sq_empty
);
    logic [SQ_NUM-1:0]   valid_q, valid_d, ready_q, ready_d, committed_q, committed_d;
    logic [ADDR_LEN-1:0] addr_q [SQ_NUM];
    logic [ADDR_LEN-1:0] addr_d [SQ_NUM];
    logic [DATA_LEN-1:0] data_q [SQ_NUM];
    logic [DATA_LEN-1:0] data_d [SQ_NUM];
    logic [ROB_SEL-1:0]  rob_q  [SQ_NUM];
    logic [ROB_SEL-1:0]  rob_d  [SQ_NUM];
    sq_ptr_t             head_q, head_d, commit_q, commit_d, tail_q, tail_d, count_q, count_d;
    drain_state_t        state_q, state_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_LEN-1:0] mem_req_addr_q, mem_req_addr_d;
    logic [DATA_LEN-1:0] mem_req_data_q, mem_req_data_d;
    logic                sq_full_q, sq_full_d, sq_empty_q, sq_empty_d;

    logic                acc_1_s, acc_2_s;
    logic [SQ_SEL-1:0]   head_slot_s, slot_2_s, scan_slot_s;
    sq_ptr_t             flush_len_s;

    assign head_slot_s = slot_of(head_q);
    assign sq_idx_1    = slot_of(tail_q);
    assign sq_idx_2    = dispatch_sq_valid_1 ? slot_of(tail_q + sq_ptr_t'(1'b1)) : slot_of(tail_q);

    // Dispatch is all-or-nothing and suppressed during a flush.
    always_comb begin
        acc_1_s = 1'b0;
        acc_2_s = 1'b0;
        if (flush) begin
            acc_1_s = 1'b0;
        end else if (dispatch_sq_valid_1 && dispatch_sq_valid_2) begin
            acc_1_s = (count_q < sq_ptr_t'(SQ_NUM - 1));
            acc_2_s = acc_1_s;
        end else begin
            acc_1_s = dispatch_sq_valid_1 && !sq_full_q;
            acc_2_s = dispatch_sq_valid_2 && !sq_full_q;
        end
        slot_2_s = acc_1_s ? slot_of(tail_q + sq_ptr_t'(1'b1)) : slot_of(tail_q);
    end

    // Next-state for entries, pointers and the drain request.
    always_comb begin
        valid_d         = valid_q;
        ready_d         = ready_q;
        committed_d     = committed_q;
        addr_d          = addr_q;
        data_d          = data_q;
        rob_d           = rob_q;
        head_d          = head_q;
        commit_d        = commit_q + sq_ptr_t'(commit_cnt);
        tail_d          = tail_q;
        state_d         = state_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;
        scan_slot_s     = '0;
        flush_len_s     = tail_q - commit_d;

        if (exec_valid && valid_q[exec_sq_idx]) begin
            addr_d[exec_sq_idx]  = exec_addr;
            data_d[exec_sq_idx]  = exec_data;
            ready_d[exec_sq_idx] = 1'b1;
        end else begin
            ready_d = ready_d;
        end

        for (int k = 0; k < 3; k++) begin
            scan_slot_s = slot_of(commit_q + sq_ptr_t'(k));
            if (sq_ptr_t'(k) < sq_ptr_t'(commit_cnt)) begin
                committed_d[scan_slot_s] = 1'b1;
            end else begin
                committed_d = committed_d;
            end
        end

        if (flush) begin
            tail_d = commit_d;
            for (int k = 0; k < SQ_NUM; k++) begin
                scan_slot_s = slot_of(commit_d + sq_ptr_t'(k));
                if (sq_ptr_t'(k) < flush_len_s) begin
                    valid_d[scan_slot_s]     = 1'b0;
                    ready_d[scan_slot_s]     = 1'b0;
                    committed_d[scan_slot_s] = 1'b0;
                end else begin
                    valid_d = valid_d;
                end
            end
        end else begin
            if (acc_1_s) begin
                valid_d[sq_idx_1]     = 1'b1;
                ready_d[sq_idx_1]     = 1'b0;
                committed_d[sq_idx_1] = 1'b0;
                rob_d[sq_idx_1]       = rob_idx_1;
            end else begin
                valid_d = valid_d;
            end
            if (acc_2_s) begin
                valid_d[slot_2_s]     = 1'b1;
                ready_d[slot_2_s]     = 1'b0;
                committed_d[slot_2_s] = 1'b0;
                rob_d[slot_2_s]       = rob_idx_2;
            end else begin
                valid_d = valid_d;
            end
            tail_d = tail_q + sq_ptr_t'(acc_1_s) + sq_ptr_t'(acc_2_s);
        end

        // The idle cycle after every pop is the bubble: IDLE only looks at registered state.
        case (state_q)
            DRAIN_IDLE: begin
                if (valid_q[head_slot_s] && committed_q[head_slot_s] && ready_q[head_slot_s]) begin
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = addr_q[head_slot_s];
                    mem_req_data_d  = data_q[head_slot_s];
                    state_d         = DRAIN_REQ;
                end else begin
                    state_d = DRAIN_IDLE;
                end
            end
            DRAIN_REQ: begin
                if (mem_req_ready) begin
                    valid_d[head_slot_s]     = 1'b0;
                    ready_d[head_slot_s]     = 1'b0;
                    committed_d[head_slot_s] = 1'b0;
                    head_d                   = head_q + sq_ptr_t'(1'b1);
                    mem_req_valid_d          = 1'b0;
                    state_d                  = DRAIN_IDLE;
                end else begin
                    state_d = DRAIN_REQ;
                end
            end
            default: begin
                mem_req_valid_d = 1'b0;
                state_d         = DRAIN_IDLE;
            end
        endcase

        count_d    = tail_d - head_d;
        sq_full_d  = (count_d >= sq_ptr_t'(SQ_NUM - 1));
        sq_empty_d = (count_d == sq_ptr_t'(0));
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q         <= '0;
            ready_q         <= '0;
            committed_q     <= '0;
            for (int i = 0; i < SQ_NUM; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                rob_q[i]  <= '0;
            end
            head_q          <= '0;
            commit_q        <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            state_q         <= DRAIN_IDLE;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
            sq_full_q       <= 1'b0;
            sq_empty_q      <= 1'b1;
        end else begin
            valid_q         <= valid_d;
            ready_q         <= ready_d;
            committed_q     <= committed_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            rob_q           <= rob_d;
            head_q          <= head_d;
            commit_q        <= commit_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            state_q         <= state_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
            sq_full_q       <= sq_full_d;
            sq_empty_q      <= sq_empty_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_data  = mem_req_data_q;
    assign sq_full       = sq_full_q;
    assign sq_empty      = sq_empty_q;

    sq_fwd_search u_fwd (
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_sq_tail (ld_sq_tail),
        .head       (head_q),
        .valid      (valid_q),
        .ready      (ready_q),
        .addr       (addr_q),
        .data       (data_q),
        .hit        (fwd_hit),
        .hit_data   (fwd_data)
    );
endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: queue-based reference model compared every cycle plus
// directed scenarios with literal expectations.
module tb_store_queue;
    import store_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_sq_valid_1, dispatch_sq_valid_2;
    logic [5:0]  rob_idx_1, rob_idx_2;
    logic [2:0]  sq_idx_1, sq_idx_2;
    logic        exec_valid;
    logic [2:0]  exec_sq_idx;
    logic [31:0] exec_addr, exec_data;
    logic [1:0]  commit_cnt;
    logic        flush;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [3:0]  ld_sq_tail;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr, mem_req_data;
    logic        mem_req_ready;
    logic        sq_full, sq_empty;

    always #5 clk = ~clk;

    store_queue dut (
        .clk(clk), .reset(reset),
        .dispatch_sq_valid_1(dispatch_sq_valid_1), .dispatch_sq_valid_2(dispatch_sq_valid_2),
        .rob_idx_1(rob_idx_1), .rob_idx_2(rob_idx_2),
        .sq_idx_1(sq_idx_1), .sq_idx_2(sq_idx_2),
        .exec_valid(exec_valid), .exec_sq_idx(exec_sq_idx),
        .exec_addr(exec_addr), .exec_data(exec_data),
        .commit_cnt(commit_cnt), .flush(flush),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_sq_tail(ld_sq_tail),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
        .sq_full(sq_full), .sq_empty(sq_empty)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order list of live stores, oldest first.
    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_e;
    int          m_head = 0;
    int          m_ncom = 0;
    int          m_sz, m_p;
    bit          m_pop;
    bit          m_req_v = 1'b0;
    logic [31:0] m_req_a = 32'h0;
    logic [31:0] m_req_d = 32'h0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_head  = 0;
            m_ncom  = 0;
            m_req_v = 1'b0;
            m_req_a = 32'h0;
            m_req_d = 32'h0;
        end else begin
            m_sz  = mq.size();
            m_pop = m_req_v && mem_req_ready;
            if (m_req_v) begin
                if (mem_req_ready) m_req_v = 1'b0;
            end else if (m_sz > 0 && m_ncom > 0 && mq[0].rdy) begin
                m_req_v = 1'b1;
                m_req_a = mq[0].addr;
                m_req_d = mq[0].data;
            end
            if (exec_valid) begin
                m_p = (int'(exec_sq_idx) - m_head + 16) % 8;
                if (m_p < m_sz) begin
                    m_e = mq[m_p];
                    m_e.addr = exec_addr;
                    m_e.data = exec_data;
                    m_e.rdy  = 1'b1;
                    mq[m_p] = m_e;
                end
            end
            m_ncom += int'(commit_cnt);
            if (flush) begin
                while (mq.size() > m_ncom) void'(mq.pop_back());
            end else if (dispatch_sq_valid_1 && dispatch_sq_valid_2) begin
                if (m_sz < 7) begin
                    mq.push_back('{rob: rob_idx_1, addr: 32'h0, data: 32'h0, rdy: 1'b0});
                    mq.push_back('{rob: rob_idx_2, addr: 32'h0, data: 32'h0, rdy: 1'b0});
                end
            end else if (dispatch_sq_valid_1 || dispatch_sq_valid_2) begin
                if (m_sz < 7)
                    mq.push_back('{rob: (dispatch_sq_valid_1 ? rob_idx_1 : rob_idx_2),
                                   addr: 32'h0, data: 32'h0, rdy: 1'b0});
            end
            if (m_pop) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % 16;
                m_ncom--;
            end
        end
    end

    int          e_tail, e_n;
    bit          e_hit;
    logic [31:0] e_data;

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        e_tail = (m_head + mq.size()) % 16;
        chk("sq_idx_1", sq_idx_1, e_tail % 8);
        chk("sq_idx_2", sq_idx_2, dispatch_sq_valid_1 ? (e_tail + 1) % 8 : e_tail % 8);
        chk("sq_full", sq_full, mq.size() >= 7);
        chk("sq_empty", sq_empty, mq.size() == 0);
        chk("mem_req_valid", mem_req_valid, m_req_v);
        if (m_req_v) begin
            chk("mem_req_addr", mem_req_addr, m_req_a);
            chk("mem_req_data", mem_req_data, m_req_d);
        end
        e_hit  = 1'b0;
        e_data = 32'h0;
        if (ld_valid) begin
            e_n = (int'(ld_sq_tail) - m_head + 16) % 16;
            if (e_n > mq.size()) e_n = mq.size();
            if (e_n > 0 && mq[e_n-1].rdy) begin
                for (int k = e_n - 1; k >= 0; k--) begin
                    if (!e_hit && mq[k].rdy && mq[k].addr == ld_addr) begin
                        e_hit  = 1'b1;
                        e_data = mq[k].data;
                    end
                end
            end
        end
        chk("fwd_hit", fwd_hit, e_hit);
        chk("fwd_data", fwd_data, e_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        dispatch_sq_valid_1 = 1'b0;
        dispatch_sq_valid_2 = 1'b0;
        exec_valid          = 1'b0;
        commit_cnt          = 2'd0;
        flush               = 1'b0;
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (!mem_req_valid && n < budget) begin
            tick();
            n++;
        end
        chk("wait_req_timeout", mem_req_valid, 1'b1);
    endtask

    logic [2:0] slot;

    initial begin
        reset = 1'b1;
        dispatch_sq_valid_1 = 1'b0; dispatch_sq_valid_2 = 1'b0;
        rob_idx_1 = 6'd0; rob_idx_2 = 6'd0;
        exec_valid = 1'b0; exec_sq_idx = 3'd0; exec_addr = 32'h0; exec_data = 32'h0;
        commit_cnt = 2'd0; flush = 1'b0;
        ld_valid = 1'b0; ld_addr = 32'h0; ld_sq_tail = 4'd0;
        mem_req_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_empty", sq_empty, 1'b1);
        chk("rst_full", sq_full, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_req_addr", mem_req_addr, 32'h0);

        // Drain held by a stalled D-cache.
        dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'd1; tick();
        exec_valid = 1'b1; exec_sq_idx = 3'd0; exec_addr = 32'h100; exec_data = 32'hAA; tick();
        commit_cnt = 2'd1; tick();
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("hold_valid", mem_req_valid, 1'b1);
            chk("hold_addr", mem_req_addr, 32'h100);
            chk("hold_data", mem_req_data, 32'hAA);
            tick();
        end
        mem_req_ready = 1'b1; tick();
        mem_req_ready = 1'b0;
        chk("pop_valid", mem_req_valid, 1'b0);
        chk("pop_empty", sq_empty, 1'b1);
        chk("pop_tail", sq_idx_1, 3'd1);

        // Asynchronous reset in the middle of a request.
        dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'd2; tick();
        exec_valid = 1'b1; exec_sq_idx = 3'd1; exec_addr = 32'h104; exec_data = 32'hBB; tick();
        commit_cnt = 2'd1; tick();
        tick();
        chk("mid_req_valid", mem_req_valid, 1'b1);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        chk("areset_valid", mem_req_valid, 1'b0);
        chk("areset_empty", sq_empty, 1'b1);
        chk("areset_tail", sq_idx_1, 3'd0);
        tick();

        // Dual dispatch to full.
        for (int w = 0; w < 4; w++) begin
            dispatch_sq_valid_1 = 1'b1; dispatch_sq_valid_2 = 1'b1;
            rob_idx_1 = 6'(2*w + 1); rob_idx_2 = 6'(2*w + 2);
            #1;
            chk("dual_idx1", sq_idx_1, 2*w);
            chk("dual_idx2", sq_idx_2, 2*w + 1);
            tick();
        end
        chk("dual_full", sq_full, 1'b1);
        for (int i = 0; i < 8; i++) chk("rob_stored", dut.rob_q[i], i + 1);
        dispatch_sq_valid_1 = 1'b1; dispatch_sq_valid_2 = 1'b1; tick();
        chk("dual_drop", sq_idx_1, 3'd0);
        dispatch_sq_valid_1 = 1'b1; tick();
        chk("single_drop", sq_idx_1, 3'd0);

        // Fill in addresses, commit everything, then dispatch alongside pops.
        for (int i = 0; i < 8; i++) begin
            exec_valid = 1'b1; exec_sq_idx = 3'(i);
            exec_addr = 32'h200 + 32'(4*i); exec_data = 32'h1000 + 32'(i);
            tick();
        end
        repeat (4) begin commit_cnt = 2'd2; tick(); end
        wait_req(6);
        chk("first_drain_addr", mem_req_addr, 32'h200);
        mem_req_ready = 1'b1; tick();
        mem_req_ready = 1'b0;
        chk("count7_full", sq_full, 1'b1);
        wait_req(4);
        mem_req_ready = 1'b1; dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'd9; tick();
        mem_req_ready = 1'b0;
        chk("full_single_drop", sq_full, 1'b0);
        chk("full_single_tail", sq_idx_1, 3'd0);
        wait_req(4);
        mem_req_ready = 1'b1; dispatch_sq_valid_1 = 1'b1; dispatch_sq_valid_2 = 1'b1;
        rob_idx_1 = 6'd10; rob_idx_2 = 6'd11; tick();
        mem_req_ready = 1'b0;
        chk("net_full", sq_full, 1'b1);
        chk("net_tail", sq_idx_1, 3'd2);

        // Forwarding.
        reset = 1'b1; #2 reset = 1'b0; tick();
        dispatch_sq_valid_1 = 1'b1; dispatch_sq_valid_2 = 1'b1;
        rob_idx_1 = 6'd1; rob_idx_2 = 6'd2; tick();
        exec_valid = 1'b1; exec_sq_idx = 3'd0; exec_addr = 32'h40; exec_data = 32'h11; tick();
        ld_valid = 1'b1; ld_addr = 32'h40; ld_sq_tail = 4'd2; #1;
        chk("fwd_young_unknown", fwd_hit, 1'b0);
        exec_valid = 1'b1; exec_sq_idx = 3'd1; exec_addr = 32'h40; exec_data = 32'h22; tick();
        chk("fwd_t2_hit", fwd_hit, 1'b1);
        chk("fwd_t2_data", fwd_data, 32'h22);
        ld_sq_tail = 4'd1; #1;
        chk("fwd_t1_data", fwd_data, 32'h11);
        ld_sq_tail = 4'd0; #1;
        chk("fwd_t0_hit", fwd_hit, 1'b0);
        ld_sq_tail = 4'd2; ld_addr = 32'h44; #1;
        chk("fwd_addr_miss", fwd_hit, 1'b0);
        ld_valid = 1'b0; ld_addr = 32'h40; #1;
        chk("fwd_no_req", fwd_hit, 1'b0);

        // Flush keeps only the committed store.
        dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'd3; tick();
        exec_valid = 1'b1; exec_sq_idx = 3'd2; exec_addr = 32'h48; exec_data = 32'h33; tick();
        commit_cnt = 2'd1; tick();
        flush = 1'b1; tick();
        chk("flush_tail", sq_idx_1, 3'd1);
        chk("flush_empty", sq_empty, 1'b0);
        mem_req_ready = 1'b1;
        wait_req(4);
        chk("flush_drain_addr", mem_req_addr, 32'h40);
        chk("flush_drain_data", mem_req_data, 32'h11);
        repeat (5) tick();
        chk("flush_done_empty", sq_empty, 1'b1);
        chk("flush_done_idle", mem_req_valid, 1'b0);

        // Wrap the pointers with a stream of single stores.
        for (int s = 0; s < SQ_NUM + 3; s++) begin
            slot = 3'((m_head + mq.size()) % 8);
            dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'(20 + s); tick();
            exec_valid = 1'b1; exec_sq_idx = slot;
            exec_addr = 32'h300 + 32'(4*s); exec_data = 32'h5000 + 32'(s); tick();
            commit_cnt = 2'd1; tick();
            repeat (3) tick();
        end
        chk("wrap_tail", sq_idx_1, 3'd4);
        chk("wrap_empty", sq_empty, 1'b1);
        mem_req_ready = 1'b0;
        for (int s = 0; s < 7; s++) begin
            dispatch_sq_valid_1 = 1'b1; rob_idx_1 = 6'(40 + s); tick();
        end
        chk("wrap_full", sq_full, 1'b1);
        chk("wrap_not_empty", sq_empty, 1'b0);
        flush = 1'b1; tick();
        chk("wrap_flush_empty", sq_empty, 1'b1);
        chk("wrap_flush_tail", sq_idx_1, 3'd4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
